// File: rtl/debug_trace_pkg.sv
// Shared encodings and display constants for debug_trace_mux and its capture buffer.
// Constants only; no latency and no backpressure.
package debug_trace_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_FROZEN  = 2'd3;

  localparam logic [31:0] BLANK_WORD = 32'h0000_0FF0;
  localparam logic [31:0] ERROR_WORD = 32'h0000_DEDE;
endpackage

// File: rtl/debug_trace_buffer.sv
// Capture storage: one write port, one combinational read port with write-first bypass.
// Write lands on the clock edge; no backpressure, the writer owns the index.
module debug_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_vld,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_dat
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_vld) mem_q[wr_idx] <= wr_dat;
  end

  // A read of the entry being written returns the incoming word.
  assign rd_dat = (wr_vld && (wr_idx == rd_idx)) ? wr_dat : mem_q[rd_idx];
endmodule

// File: rtl/debug_trace_mux.sv
// Debug channel mux with registered display (1 cycle) plus capture FSM; DEBUG_TRACE_TRIGGER_MATCH_EN adds ARMED/trigger.
// No backpressure: every strobe in CAPTURE is taken until the buffer is full, then it freezes.
module debug_trace_mux
  import debug_trace_pkg::*;
#(
  parameter int NUM_CH = 64,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int SEL_W  = $clog2(NUM_CH),
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [NUM_CH*DATA_W-1:0] Channel_Data,
  input  logic [SEL_W-1:0]         Display_Select,
  input  logic                     Display_Blank,
  input  logic                     View_Trace,
  input  logic [IDX_W-1:0]         View_Index,
  input  logic                     Sample_Strobe,
  input  logic                     Arm,
  input  logic                     Clear,
`ifdef DEBUG_TRACE_TRIGGER_MATCH_EN
  input  logic [DATA_W-1:0]        Trigger_Value,
`endif
  output logic [DATA_W-1:0]        HexDisplay32Bits,
  output logic [1:0]               Trace_State,
  output logic [IDX_W:0]           Sample_Count
);
  localparam logic [DATA_W-1:0] BLANK_D = DATA_W'(BLANK_WORD);
  localparam logic [DATA_W-1:0] ERROR_D = DATA_W'(ERROR_WORD);
  localparam logic [IDX_W:0]    FULL    = (IDX_W+1)'(DEPTH);
`ifdef DEBUG_TRACE_TRIGGER_MATCH_EN
  localparam logic [1:0]        ARM_NEXT = ST_ARMED;
`else
  localparam logic [1:0]        ARM_NEXT = ST_CAPTURE;
`endif

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]    count_q, count_d;
  logic [SEL_W-1:0]  cap_sel_q, cap_sel_d;
  logic [DATA_W-1:0] disp_q, disp_d;
  logic [DATA_W-1:0] chan [NUM_CH];
  logic [DATA_W-1:0] live_dat, cap_dat, rd_dat;
  logic              take_vld;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    assign chan[k] = Channel_Data[k*DATA_W +: DATA_W];
  end

  assign live_dat = (32'(Display_Select) < NUM_CH) ? chan[Display_Select] : ERROR_D;
  assign cap_dat  = (32'(cap_sel_q) < NUM_CH) ? chan[cap_sel_q] : ERROR_D;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    cap_sel_d = cap_sel_q;
    take_vld  = 1'b0;
    if (Clear) begin
      state_d  = ST_IDLE;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Arm) begin
            state_d   = ARM_NEXT;
            cap_sel_d = Display_Select;
            wr_ptr_d  = '0;
            count_d   = '0;
          end
        end
`ifdef DEBUG_TRACE_TRIGGER_MATCH_EN
        ST_ARMED: begin
          // The matching sample itself becomes entry 0.
          if (Sample_Strobe && (cap_dat == Trigger_Value)) begin
            take_vld = 1'b1;
            state_d  = ST_CAPTURE;
          end
        end
`endif
        ST_CAPTURE: take_vld = Sample_Strobe;
        default: ;
      endcase
      if (take_vld) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
        if (count_d == FULL) state_d = ST_FROZEN;
      end
    end
  end

  debug_trace_buffer #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_buf (
    .clk    (Clock),
    .wr_vld (take_vld & ~Reset),
    .wr_idx (wr_ptr_q),
    .wr_dat (cap_dat),
    .rd_idx (View_Index),
    .rd_dat (rd_dat)
  );

  // Validity uses the post-edge count so a same-cycle write is visible.
  always_comb begin
    disp_d = live_dat;
    if (Display_Blank)   disp_d = BLANK_D;
    else if (View_Trace) disp_d = ({1'b0, View_Index} < count_d) ? rd_dat : ERROR_D;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      cap_sel_q <= '0;
      disp_q    <= BLANK_D;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      cap_sel_q <= cap_sel_d;
      disp_q    <= disp_d;
    end
  end

  assign HexDisplay32Bits = disp_q;
  assign Trace_State      = state_q;
  assign Sample_Count     = count_q;
endmodule

// File: tb/tb_debug_trace_mux.sv
// Bench for debug_trace_mux: queue-based trace model checked every cycle, plus literal checks.
// Uses NUM_CH=12 so that Display_Select can address a non-existent channel.
module tb_debug_trace_mux;
  localparam int NUM_CH = 12;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int SEL_W  = $clog2(NUM_CH);
  localparam int IDX_W  = $clog2(DEPTH);

  logic                     clk = 1'b0;
  logic                     Reset, Display_Blank, View_Trace, Sample_Strobe, Arm, Clear;
  logic [SEL_W-1:0]         Display_Select;
  logic [IDX_W-1:0]         View_Index;
  logic [NUM_CH*DATA_W-1:0] chan_flat;
  logic [DATA_W-1:0]        ch [NUM_CH];
  logic [DATA_W-1:0]        HexDisplay32Bits;
  logic [1:0]               Trace_State;
  logic [IDX_W:0]           Sample_Count;
`ifdef DEBUG_TRACE_TRIGGER_MATCH_EN
  logic [DATA_W-1:0]        Trigger_Value = '0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the trace is simply the list of captured words, oldest first.
  int                m_state = 0;
  int                m_cap   = 0;
  logic [DATA_W-1:0] m_disp  = 32'h0000_0FF0;
  logic [DATA_W-1:0] m_trace [$];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_flat
    assign chan_flat[k*DATA_W +: DATA_W] = ch[k];
  end

  debug_trace_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .Clock            (clk),
    .Reset            (Reset),
    .Channel_Data     (chan_flat),
    .Display_Select   (Display_Select),
    .Display_Blank    (Display_Blank),
    .View_Trace       (View_Trace),
    .View_Index       (View_Index),
    .Sample_Strobe    (Sample_Strobe),
    .Arm              (Arm),
    .Clear            (Clear),
`ifdef DEBUG_TRACE_TRIGGER_MATCH_EN
    .Trigger_Value    (Trigger_Value),
`endif
    .HexDisplay32Bits (HexDisplay32Bits),
    .Trace_State      (Trace_State),
    .Sample_Count     (Sample_Count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [DATA_W-1:0] cur, trig;
    int idx;
    trig = '0;
`ifdef DEBUG_TRACE_TRIGGER_MATCH_EN
    trig = Trigger_Value;
`endif
    if (Reset) begin
      m_state = 0; m_cap = 0; m_trace.delete(); m_disp = 32'h0000_0FF0;
      return;
    end
    if (Clear) begin
      m_state = 0; m_trace.delete();
    end else if (m_state == 0 && Arm) begin
`ifdef DEBUG_TRACE_TRIGGER_MATCH_EN
      m_state = 1;
`else
      m_state = 2;
`endif
      m_cap = int'(Display_Select);
      m_trace.delete();
    end else if (Sample_Strobe) begin
      cur = ch[m_cap];
      if (m_state == 2 || (m_state == 1 && cur == trig)) begin
        m_trace.push_back(cur);
        m_state = (m_trace.size() == DEPTH) ? 3 : 2;
      end
    end
    idx = int'(View_Index);
    if (Display_Blank)                       m_disp = 32'h0000_0FF0;
    else if (View_Trace)                     m_disp = (idx < m_trace.size()) ? m_trace[idx] : 32'h0000_DEDE;
    else if (int'(Display_Select) >= NUM_CH) m_disp = 32'h0000_DEDE;
    else                                     m_disp = ch[Display_Select];
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check("model_disp",  HexDisplay32Bits, m_disp);
      check("model_state", 32'(Trace_State), 32'(m_state));
      check("model_count", 32'(Sample_Count), 32'(m_trace.size()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Display_Blank = 1'b0; View_Trace = 1'b0; Sample_Strobe = 1'b0;
    Arm = 1'b0; Clear = 1'b0; Display_Select = '0; View_Index = '0;
    for (int k = 0; k < NUM_CH; k++) ch[k] = 32'hA000_0000 + 32'(k);
    ch[5] = 32'h1234_5678;
    step(); step();
    check("rst_disp",  HexDisplay32Bits, 32'h0000_0FF0);
    check("rst_state", 32'(Trace_State), 32'd0);
    check("rst_count", 32'(Sample_Count), 32'd0);
    Reset = 1'b0;

    Display_Select = 4'd5; step();
    check("live_ch5", HexDisplay32Bits, 32'h1234_5678);
    check("live_state", 32'(Trace_State), 32'd0);
    Display_Blank = 1'b1; step();
    check("blank", HexDisplay32Bits, 32'h0000_0FF0);
    Display_Blank = 1'b0; Display_Select = 4'(NUM_CH); step();
    check("bad_select", HexDisplay32Bits, 32'h0000_DEDE);

    // Full capture of channel 1 with a mid-run select change, bypass read and a stray Arm.
    Display_Select = 4'd1; Arm = 1'b1; step(); Arm = 1'b0;
    check("armed_state", 32'(Trace_State), 32'd2);
    for (int i = 0; i < DEPTH; i++) begin
      ch[1] = 32'(i);
      Sample_Strobe = 1'b1;
      if (i == 5) begin View_Trace = 1'b1; View_Index = 4'd5; end
      if (i == 8) Display_Select = 4'd7;
      if (i == 10) Arm = 1'b1;
      step();
      Sample_Strobe = 1'b0; Arm = 1'b0;
      if (i == 5) begin
        check("bypass_rd", HexDisplay32Bits, 32'h5);
        View_Trace = 1'b0;
      end
    end
    check("full_state", 32'(Trace_State), 32'd3);
    check("full_count", 32'(Sample_Count), 32'd16);
    View_Trace = 1'b1; View_Index = 4'd3; step();
    check("view3", HexDisplay32Bits, 32'h3);
    ch[1] = 32'hAAAA_AAAA; Sample_Strobe = 1'b1; step(); step(); Sample_Strobe = 1'b0;
    View_Index = 4'd15; step();
    check("frozen_view15", HexDisplay32Bits, 32'hF);
    check("frozen_count", 32'(Sample_Count), 32'd16);

    // Partial capture; Arm with a simultaneous strobe writes nothing.
    Clear = 1'b1; step(); Clear = 1'b0;
    check("clear_state", 32'(Trace_State), 32'd0);
    Display_Select = 4'd1; Arm = 1'b1; Sample_Strobe = 1'b1; step();
    Arm = 1'b0; Sample_Strobe = 1'b0;
    check("arm_nowrite", 32'(Sample_Count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      ch[1] = 32'(100 + i); Sample_Strobe = 1'b1; step(); Sample_Strobe = 1'b0;
    end
    View_Index = 4'd6; step();
    check("partial_oob", HexDisplay32Bits, 32'h0000_DEDE);
    View_Index = 4'd2; step();
    check("partial_view2", HexDisplay32Bits, 32'd102);
    Clear = 1'b1; Sample_Strobe = 1'b1; step(); Clear = 1'b0; Sample_Strobe = 1'b0;
    check("clr_strobe_state", 32'(Trace_State), 32'd0);
    check("clr_strobe_count", 32'(Sample_Count), 32'd0);

    // Reset in the middle of a capture.
    View_Trace = 1'b0; Arm = 1'b1; step(); Arm = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ch[1] = 32'(200 + i); Sample_Strobe = 1'b1; step(); Sample_Strobe = 1'b0;
    end
    check("mid_count", 32'(Sample_Count), 32'd9);
    Reset = 1'b1; Sample_Strobe = 1'b1; step(); Reset = 1'b0; Sample_Strobe = 1'b0;
    check("mid_rst_state", 32'(Trace_State), 32'd0);
    check("mid_rst_count", 32'(Sample_Count), 32'd0);
    check("mid_rst_disp", HexDisplay32Bits, 32'h0000_0FF0);

`ifdef DEBUG_TRACE_TRIGGER_MATCH_EN
    Trigger_Value = 32'h20; Display_Select = 4'd1; Arm = 1'b1; step(); Arm = 1'b0;
    for (int v = 'h1E; v <= 'h20; v++) begin
      ch[1] = 32'(v); Sample_Strobe = 1'b1; step(); Sample_Strobe = 1'b0;
      if (v < 'h20) begin
        check("trig_armed", 32'(Trace_State), 32'd1);
        check("trig_nowrite", 32'(Sample_Count), 32'd0);
      end
    end
    check("trig_capture", 32'(Trace_State), 32'd2);
    View_Trace = 1'b1; View_Index = 4'd0; step();
    check("trig_entry0", HexDisplay32Bits, 32'h20);
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/debug_trace_mux.md
Name: debug_trace_mux

Overview:
- Parametrised successor to the processor's hex-display debug mux.
- Selects one of NUM_CH debug channels for the hex display, with a registered output.
- Adds a DEPTH-entry capture buffer that records the selected channel on each Sample_Strobe (typically Stage==0), then freezes it for step-by-step readback on the hex displays.
- Sits between the datapath/control-unit debug taps and the HEX decoder.

Parameters:
- NUM_CH, 64: number of debug channels; channel k occupies Channel_Data[k*DATA_W +: DATA_W].
- DATA_W, 32: channel and display width.
- DEPTH, 16: capture buffer entries; must be a power of 2 and at least 2.
- SEL_W, $clog2(NUM_CH): select width.
- IDX_W, $clog2(DEPTH): buffer index width.

Ports:
- Clock, in, 1: the single clock; all state changes on its rising edge.
- Reset, in, 1: synchronous, active-high.
- Channel_Data, in, NUM_CH*DATA_W: flattened debug taps.
- Display_Select, in, SEL_W: live channel select; also the capture channel latched at Arm.
- Display_Blank, in, 1: 1 forces the blank pattern.
- View_Trace, in, 1: 1 shows a buffer entry instead of the live channel.
- View_Index, in, IDX_W: buffer entry to show; 0 is the oldest sample.
- Sample_Strobe, in, 1: one-cycle pulse; capture one sample.
- Arm, in, 1: one-cycle pulse; start a capture.
- Clear, in, 1: one-cycle pulse; abort and return to IDLE.
- Trigger_Value, in, DATA_W: match value (TRIGGER_MATCH_EN builds only).
- HexDisplay32Bits, out, DATA_W: registered display word.
- Trace_State, out, 2: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 FROZEN.
- Sample_Count, out, IDX_W+1: number of valid buffer entries.

Behaviour:
- Reset values:
  - HexDisplay32Bits = 32'h0000_0FF0.
  - Trace_State = IDLE.
  - Sample_Count = 0.
  - Write pointer = 0.
  - Latched capture channel = 0.
  - Buffer contents are don't-care; reads are gated by Sample_Count.
- Display path, one-cycle latency, priority order:
  - Display_Blank=1 -> 32'h0000_0FF0.
  - Else View_Trace=1 and View_Index < Sample_Count -> buffer[View_Index].
  - Else View_Trace=1 and View_Index >= Sample_Count -> 32'h0000_DEDE.
  - Else Display_Select >= NUM_CH -> 32'h0000_DEDE.
  - Else -> the selected live channel.
- FSM transitions:
  - IDLE + Arm -> CAPTURE. On the same edge: latch Display_Select as the capture channel, zero the write pointer, set Sample_Count = 0. With TRIGGER_MATCH_EN, go to ARMED instead.
  - ARMED: on a Sample_Strobe cycle where the capture channel equals Trigger_Value -> CAPTURE, and that same sample is written as entry 0.
  - CAPTURE + Sample_Strobe -> write the capture channel to buffer[wr_ptr], then wr_ptr+1 and Sample_Count+1. When the write takes Sample_Count to DEPTH -> FROZEN.
  - FROZEN: hold buffer and count; ignore Arm and Sample_Strobe.
  - Any state + Clear -> IDLE, with Sample_Count = 0.
- Simultaneous events:
  - Priority is Reset > Clear > Arm > Sample_Strobe.
  - Arm and Sample_Strobe in the same IDLE cycle: arm only, no write.
  - Arm while in ARMED or CAPTURE is ignored; no restart.
- Channel binding: changing Display_Select mid-capture changes only the live display, never the captured channel.
- Read/write collision: reading buffer[View_Index] on the cycle it is written shows the newly written value, because the display register samples after the write. Implement this as write-first bypass.
- Reset mid-capture: return to IDLE on the next edge; the partial trace is discarded.
- Wrap: wr_ptr cannot wrap because capture stops at DEPTH. View_Index values out of range return DEDE and do not alias.

Optional Feature:
- Macro: DEBUG_TRACE_TRIGGER_MATCH_EN.
- Defined:
  - ARMED state exists.
  - Trigger_Value port is present.
  - Capture starts on the first strobed sample equal to Trigger_Value.
- Undefined:
  - Trigger_Value port is absent.
  - Arm goes directly to CAPTURE.
  - Encoding 1 is never output.

Decomposition:
- Package debug_trace_pkg holds:
  - Trace_State encoding localparams: IDLE=0, ARMED=1, CAPTURE=2, FROZEN=3.
  - BLANK_WORD = 32'h0000_0FF0.
  - ERROR_WORD = 32'h0000_DEDE.
- One sub-module, debug_trace_buffer: DEPTH x DATA_W storage with single write port, single read port and write-first bypass.
- The FSM and the channel mux stay in the top module.

Test Plan:
- Reset, then Display_Select=5 with channel 5 = 32'h1234_5678 -> HexDisplay32Bits = 32'h1234_5678 one cycle later; Trace_State = 0.
- Display_Blank=1 -> 32'h0000_0FF0. Display_Select=NUM_CH (invalid) -> 32'h0000_DEDE.
- Capture:
  - Stimulus: Arm with select=1 (PC). Then 16 strobes with PC = 0..15, and Display_Select changed to 7 midway.
  - Required response: Trace_State = 3, Sample_Count = 16, View_Index=3 shows 32'h3, further strobes leave the buffer unchanged.
- Partial capture then Clear:
  - After 4 strobes, View_Index=6 shows DEDE.
  - Clear and Sample_Strobe in the same cycle -> IDLE, Sample_Count = 0, no write.
- Reset asserted during CAPTURE at count 9 -> next edge: IDLE, count 0, display 0FF0.
- TRIGGER_MATCH_EN, Trigger_Value = 32'h0000_0020:
  - Strobed PC values 0x1E, 0x1F give ARMED and no writes.
  - At PC = 0x20, entry 0 = 0x20 and state becomes CAPTURE.
